inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the core's immediate generator. It accepts decoded fields (opcode, funct3, funct7, rd, rs1, rs2, 32-bit immediate) over a valid/ready input and range-checks the immediate against the same signed/unsigned rules the decoder applies. It packs each instruction into a 32-bit word and emits it as a sequential write stream into instruction memory, starting at a programmed base address. It is used by the boot/debug loader and by testbenches for round-trip checking, where `immgen(encode(x)) == x` for every legal `x`.

Parameters:
- ADDR_W, 10, word-address width of the imem write port.
- NOP_WORD, 32'h0000_0013, word written in place of an unsupported opcode.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse: load base/count, enter RUN (ignored unless IDLE)
- base_addr_i  in  ADDR_W  first word address
- count_i  in  ADDR_W+1  number of instructions to encode
- s_valid_i  in  1  field bundle valid
- s_ready_o  out  1  field bundle accepted when s_valid_i & s_ready_o
- s_opcode_i  in  7  opcode
- s_funct3_i  in  3  funct3
- s_funct7_i  in  7  funct7 (R-type only)
- s_rd_i, s_rs1_i, s_rs2_i  in  5 each  register indices
- s_imm_i  in  32  immediate, as imm_o of the decoder would present it
- m_valid_o  out  1  write request valid
- m_ready_i  in  1  imem accepts write
- m_addr_o  out  ADDR_W  word address
- m_data_o  out  32  encoded instruction
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at end of burst
- err_o  out  1  sticky error, cleared by start_i or reset
- err_addr_o  out  ADDR_W  address of first erroneous word

Behaviour:
- Clock and reset: single clock, clk_i; reset is synchronous and active-high on rst_i.
- Reset values: state IDLE; s_ready_o, m_valid_o, done_o, err_o = 0; m_addr_o, m_data_o, err_addr_o = 0.
- States:
  - IDLE: on start_i, load addr=base_addr_i, remaining=count_i, clear err_o, go to RUN. If count_i==0, go to DRAIN instead.
  - RUN: s_ready_o = (remaining!=0) & (~m_valid_o | m_ready_i). Each accept decrements remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until m_valid_o==0 or (m_valid_o & m_ready_i). Then assert done_o for 1 cycle and go to IDLE.
- Pipeline and latency:
  - One output register. An accepted bundle appears on m_* the next cycle.
  - Throughput is 1 word/cycle while m_ready_i=1.
  - m_data_o and m_addr_o stay stable while m_valid_o & ~m_ready_i.
  - addr increments by 1 per accept and wraps modulo 2^ADDR_W.
- Packing, using standard RV32I layouts:
  - R: funct7, rs2, rs1, f3, rd, op.
  - I, IL, IJ, IE: imm[11:0], rs1, f3, rd, op.
  - S: imm[11:5], rs2, rs1, f3, imm[4:0], op.
  - B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
  - UL, UA: imm[31:12], rd, op.
- Range check, so a legal immediate must round-trip through the decoder:
  - Unsigned ranges:
    - I with f3 = 1, 3 or 5: 0..4095.
    - IL with f3 = 4 or 5: 0..4095.
    - B with f3 = 6 or 7: 0..8190, even.
  - Signed ranges:
    - Other I, IL, IJ, IE, S: -2048..2047.
    - Other B: -4096..4094, even.
    - J: -2^20..2^20-2, even.
  - U: imm[11:0] must be 0.
  - R: s_imm_i is ignored.
- On violation: the word is still written with truncated fields. If err_o==0, set err_o=1 and latch err_addr_o=addr.
- Unsupported opcode: write NOP_WORD and flag an error as above.
- Boundary cases:
  - start_i is ignored while busy.
  - s_valid_i outside RUN is not accepted.
  - Reset mid-burst drops any pending m_valid_o immediately and returns to IDLE.
  - When the last accept and m_ready_i arrive in the same cycle, DRAIN lasts exactly 1 cycle.

Decomposition:
- Opcode and field macros (I/IL/IJ/IE/S/B/J/UL/UA, plus R_OPCODE 7'b0110011) and bit-range macros stay in the shared defines header used by the immediate generator. The new R_OPCODE is added there.
- The state enum (IDLE, RUN, DRAIN) goes in the shared package.
- Sub-module inst_pack: purely combinational packer plus range checker. Outputs are a 32-bit word and an err flag. It is unit-tested standalone against immgen.

Test Plan:
- ADDI x1,x0,-1 (op 0x13, f3 0, rd 1, imm 0xFFFFFFFF) at base 0x010 -> m_addr_o=0x010, m_data_o=0xFFF00093, err_o=0.
- BEQ x1,x2,-4 -> 0xFE208EE3; JAL x1,+8 -> 0x008000EF; LUI x5,0x12345000 -> 0x123452B7; 3 words at consecutive addresses, done_o pulse after the third.
- SLTIU imm=4096 as the 2nd word of a burst from base 0x3FF (ADDR_W=10) -> err_o=1, err_addr_o=0x000 (wrapped); the 3rd word is still written.
- m_ready_i held low 3 cycles with s_valid_i=1 -> s_ready_o=0, m_data_o and m_addr_o constant, no word lost or duplicated.
- count_i=0 -> done_o exactly 2 cycles after start_i, no m_valid_o. Reset asserted mid-burst -> next cycle IDLE, m_valid_o=0, busy_o=0.
- Random legal field bundles -> immgen(m_data_o)==s_imm_i for all non-R opcodes, err_o=0.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared types, opcodes and immediate-range helpers for the RV32I instruction encoder.
// No timing of its own: pure declarations and combinational helper functions.
// No flow control here; the encoder top handles valid/ready.
package inst_encoder_pkg;

   // Burst controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // RV32I major opcodes, named after the immediate format the decoder uses
   localparam logic [6:0] OPC_I  = 7'b0010011; // OP-IMM
   localparam logic [6:0] OPC_IL = 7'b0000011; // LOAD
   localparam logic [6:0] OPC_IJ = 7'b1100111; // JALR
   localparam logic [6:0] OPC_IE = 7'b1110011; // SYSTEM
   localparam logic [6:0] OPC_S  = 7'b0100011; // STORE
   localparam logic [6:0] OPC_B  = 7'b1100011; // BRANCH
   localparam logic [6:0] OPC_J  = 7'b1101111; // JAL
   localparam logic [6:0] OPC_UL = 7'b0110111; // LUI
   localparam logic [6:0] OPC_UA = 7'b0010111; // AUIPC
   localparam logic [6:0] OPC_R  = 7'b0110011; // OP (register-register)

   // True when v is a sign-extension of its low (msb+1) bits, i.e. bits [31:msb] all equal
   function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
      logic [31:0] t;
      t = $unsigned($signed(v) >>> msb);
      return (t == '0) || (t == '1);
   endfunction

   // True when v is a zero-extension of its low nbits bits
   function automatic logic fits_unsigned(input logic [31:0] v, input logic [4:0] nbits);
      return (v >> nbits) == '0;
   endfunction

endpackage

// File: rtl/inst_pack.sv
// Packs decoded RV32I fields into a 32-bit word and range-checks the immediate.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module inst_pack
   import inst_encoder_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        err_o
);

   // Select layout by opcode; the immediate must be exactly what the decoder would regenerate
   always_comb begin
      word_o = NOP_WORD;
      err_o  = 1'b0;
      unique case (opcode_i)
         OPC_R: begin
            word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         end
         OPC_I: begin
            word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            // shifts and SLTIU see a zero-extended immediate in the decoder
            if (funct3_i == 3'd1 || funct3_i == 3'd3 || funct3_i == 3'd5)
               err_o = !fits_unsigned(imm_i, 5'd12);
            else
               err_o = !fits_signed(imm_i, 5'd11);
         end
         OPC_IL: begin
            word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            // LBU/LHU offsets are zero-extended by the decoder
            if (funct3_i == 3'd4 || funct3_i == 3'd5)
               err_o = !fits_unsigned(imm_i, 5'd12);
            else
               err_o = !fits_signed(imm_i, 5'd11);
         end
         OPC_IJ, OPC_IE: begin
            word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            err_o  = !fits_signed(imm_i, 5'd11);
         end
         OPC_S: begin
            word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            err_o  = !fits_signed(imm_i, 5'd11);
         end
         OPC_B: begin
            word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
            // BLTU/BGEU offsets are zero-extended by the decoder
            if (funct3_i == 3'd6 || funct3_i == 3'd7)
               err_o = imm_i[0] || !fits_unsigned(imm_i, 5'd13);
            else
               err_o = imm_i[0] || !fits_signed(imm_i, 5'd12);
         end
         OPC_J: begin
            word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            err_o  = imm_i[0] || !fits_signed(imm_i, 5'd20);
         end
         OPC_UL, OPC_UA: begin
            word_o = {imm_i[31:12], rd_i, opcode_i};
            err_o  = (imm_i[11:0] != 12'd0);
         end
         default: begin
            word_o = NOP_WORD;
            err_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Streams encoded RV32I words into imem from a programmed base for a programmed count.
// Latency: one output register, accepted bundle appears on m_* the next cycle; 1 word/cycle.
// Backpressure: s_ready_o drops while the output word is stalled (m_valid_o & ~m_ready_i).
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   count_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [6:0]        s_opcode_i,
   input  logic [2:0]        s_funct3_i,
   input  logic [6:0]        s_funct7_i,
   input  logic [4:0]        s_rd_i,
   input  logic [4:0]        s_rs1_i,
   input  logic [4:0]        s_rs2_i,
   input  logic [31:0]       s_imm_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [31:0]       m_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] err_addr_o
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic                m_valid_q, m_valid_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [31:0]         m_data_q, m_data_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

   logic                s_ready;
   logic                accept;
   logic [31:0]         pack_word;
   logic                pack_err;

   inst_pack #(
      .NOP_WORD (NOP_WORD)
   ) u_pack (
      .opcode_i (s_opcode_i),
      .funct3_i (s_funct3_i),
      .funct7_i (s_funct7_i),
      .rd_i     (s_rd_i),
      .rs1_i    (s_rs1_i),
      .rs2_i    (s_rs2_i),
      .imm_i    (s_imm_i),
      .word_o   (pack_word),
      .err_o    (pack_err)
   );

   // Accept only in RUN with words left and the output slot free or draining this cycle
   assign s_ready = (state_q == RUN) && (rem_q != '0) && (!m_valid_q || m_ready_i);
   assign accept  = s_valid_i && s_ready;

   // Next-state, output register and error capture
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      m_valid_d  = m_valid_q;
      m_addr_d   = m_addr_q;
      m_data_d   = m_data_q;
      done_d     = 1'b0;
      err_d      = err_q;
      err_addr_d = err_addr_q;

      if (m_valid_q && m_ready_i)
         m_valid_d = 1'b0;

      if (accept) begin
         m_valid_d = 1'b1;
         m_addr_d  = addr_q;
         m_data_d  = pack_word;
         addr_d    = addr_q + ADDR_W'(1);
         rem_d     = rem_q - (ADDR_W+1)'(1);
         // only the first bad word of a burst is remembered
         if (pack_err && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d  = base_addr_i;
               rem_d   = count_i;
               err_d   = 1'b0;
               state_d = (count_i == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (rem_d == '0)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (!m_valid_q || m_ready_i) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         m_valid_q  <= 1'b0;
         m_addr_q   <= '0;
         m_data_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         m_valid_q  <= m_valid_d;
         m_addr_q   <= m_addr_d;
         m_data_q   <= m_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign s_ready_o  = s_ready;
   assign m_valid_o  = m_valid_q;
   assign m_addr_o   = m_addr_q;
   assign m_data_o   = m_data_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed and randomised-legal checks of the RV32I instruction encoder.
// Latency: not applicable (bench).
// Backpressure: drives m_ready_i low to exercise stalls.
module tb_inst_encoder;

   localparam int AW = 10;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW:0]   count_i;
   logic          s_valid_i;
   logic          s_ready_o;
   logic [6:0]    s_opcode_i;
   logic [2:0]    s_funct3_i;
   logic [6:0]    s_funct7_i;
   logic [4:0]    s_rd_i, s_rs1_i, s_rs2_i;
   logic [31:0]   s_imm_i;
   logic          m_valid_o;
   logic          m_ready_i;
   logic [AW-1:0] m_addr_o;
   logic [31:0]   m_data_o;
   logic          busy_o, done_o, err_o;
   logic [AW-1:0] err_addr_o;

   always #5 clk_i = ~clk_i;

   inst_encoder #(.ADDR_W(AW), .NOP_WORD(32'h0000_0013)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .count_i(count_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .s_opcode_i(s_opcode_i), .s_funct3_i(s_funct3_i), .s_funct7_i(s_funct7_i),
      .s_rd_i(s_rd_i), .s_rs1_i(s_rs1_i), .s_rs2_i(s_rs2_i), .s_imm_i(s_imm_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_addr_o(m_addr_o),
      .m_data_o(m_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .err_addr_o(err_addr_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Write and done monitor, sampled on the falling edge
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          done_cnt = 0;
   int          writes_at_done = 0;

   always @(negedge clk_i) begin
      if (m_valid_o && m_ready_i) begin
         wa_q.push_back(32'(m_addr_o));
         wd_q.push_back(m_data_o);
      end
      if (done_o) begin
         done_cnt++;
         writes_at_done = wa_q.size();
      end
   end

   function automatic logic [31:0] wr_addr(input int i);
      return (i < wa_q.size()) ? wa_q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] wr_data(input int i);
      return (i < wd_q.size()) ? wd_q[i] : 32'hDEAD_BEEF;
   endfunction

   // Decoder-side immediate generator: reconstructs imm from an encoded word
   function automatic logic [31:0] immgen(input logic [31:0] w);
      logic [2:0] f3;
      f3 = w[14:12];
      case (w[6:0])
         7'h13: return (f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5) ?
                       {20'b0, w[31:20]} : {{20{w[31]}}, w[31:20]};
         7'h03: return (f3 == 3'd4 || f3 == 3'd5) ?
                       {20'b0, w[31:20]} : {{20{w[31]}}, w[31:20]};
         7'h67, 7'h73: return {{20{w[31]}}, w[31:20]};
         7'h23: return {{20{w[31]}}, w[31:25], w[11:7]};
         7'h63: return (f3 == 3'd6 || f3 == 3'd7) ?
                       {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0} :
                       {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         7'h6F: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         7'h37, 7'h17: return {w[31:12], 12'b0};
         default: return 32'hBAD0_BAD0;
      endcase
   endfunction

   task automatic start_burst(input logic [AW-1:0] base, input logic [AW:0] cnt);
      @(posedge clk_i); #1;
      base_addr_i = base;
      count_i     = cnt;
      start_i     = 1'b1;
      @(posedge clk_i); #1;
      start_i     = 1'b0;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      s_opcode_i = op;
      s_funct3_i = f3;
      s_funct7_i = 7'd0;
      s_rd_i     = rd;
      s_rs1_i    = rs1;
      s_rs2_i    = rs2;
      s_imm_i    = imm;
      s_valid_i  = 1'b1;
   endtask

   task automatic wait_accept(input string tag);
      int n;
      n = 0;
      forever begin
         @(negedge clk_i);
         if (s_ready_o) break;
         n++;
         if (n > 50) begin
            check({tag, "_accept_timeout"}, 32'(s_ready_o), 32'd1);
            break;
         end
      end
      @(posedge clk_i); #1;
      s_valid_i = 1'b0;
   endtask

   task automatic send(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
      drive(op, f3, rd, rs1, rs2, imm);
      wait_accept(tag);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!done_o && n < 200);
      #1;
      check({tag, "_done"}, 32'(done_o), 32'd1);
   endtask

   logic [31:0] exp_imm[$];

   initial begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] r, imm;
      int          k, d0, w0;

      rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; count_i = '0;
      s_valid_i = 1'b0; m_ready_i = 1'b1;
      drive(7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      s_valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_s_ready", 32'(s_ready_o), 32'd0);
      check("rst_m_valid", 32'(m_valid_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_m_addr", 32'(m_addr_o), 32'd0);
      check("rst_m_data", m_data_o, 32'd0);
      check("rst_err_addr", 32'(err_addr_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // single ADDI x1,x0,-1 at base 0x010
      wa_q.delete(); wd_q.delete();
      start_burst(10'h010, 11'd1);
      send("addi", 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
      wait_done("addi");
      check("addi_addr", wr_addr(0), 32'h010);
      check("addi_data", wr_data(0), 32'hFFF0_0093);
      check("addi_err", 32'(err_o), 32'd0);

      // BEQ / JAL / LUI burst at 0x020
      wa_q.delete(); wd_q.delete();
      start_burst(10'h020, 11'd3);
      send("beq", 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
      send("jal", 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0008);
      send("lui", 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      wait_done("b3");
      check("b3_writes_at_done", 32'(writes_at_done), 32'd3);
      check("b3_addr0", wr_addr(0), 32'h020);
      check("b3_data0", wr_data(0), 32'hFE20_8EE3);
      check("b3_addr1", wr_addr(1), 32'h021);
      check("b3_data1", wr_data(1), 32'h0080_00EF);
      check("b3_addr2", wr_addr(2), 32'h022);
      check("b3_data2", wr_data(2), 32'h1234_52B7);
      check("b3_err", 32'(err_o), 32'd0);

      // out-of-range SLTIU as the 2nd word of a burst wrapping past 0x3FF
      wa_q.delete(); wd_q.delete();
      start_burst(10'h3FF, 11'd3);
      send("w_addi5", 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      send("w_sltiu", 7'h13, 3'd3, 5'd2, 5'd1, 5'd0, 32'd4096);
      send("w_addi1", 7'h13, 3'd0, 5'd3, 5'd0, 5'd0, 32'd1);
      wait_done("wrap");
      check("wrap_err", 32'(err_o), 32'd1);
      check("wrap_err_addr", 32'(err_addr_o), 32'h000);
      check("wrap_addr0", wr_addr(0), 32'h3FF);
      check("wrap_addr1", wr_addr(1), 32'h000);
      check("wrap_data1", wr_data(1), 32'h0000_B113);
      check("wrap_addr2", wr_addr(2), 32'h001);
      check("wrap_data2", wr_data(2), 32'h0010_0193);

      // output stall for 3 cycles with a bundle waiting; start clears the sticky error
      wa_q.delete(); wd_q.delete();
      m_ready_i = 1'b0;
      start_burst(10'h040, 11'd3);
      check("stall_err_cleared", 32'(err_o), 32'd0);
      send("st_w0", 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
      drive(7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("stall_s_ready", 32'(s_ready_o), 32'd0);
         check("stall_m_addr", 32'(m_addr_o), 32'h040);
         check("stall_m_data", m_data_o, 32'hFFF0_0093);
      end
      @(posedge clk_i); #1;
      m_ready_i = 1'b1;
      wait_accept("st_w1");
      send("st_w2", 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0008);
      wait_done("stall");
      check("stall_nwrites", 32'(wa_q.size()), 32'd3);
      check("stall_data0", wr_data(0), 32'hFFF0_0093);
      check("stall_addr1", wr_addr(1), 32'h041);
      check("stall_data1", wr_data(1), 32'h1234_52B7);
      check("stall_data2", wr_data(2), 32'h0080_00EF);

      // count 0: done exactly 2 cycles after start, no writes
      d0 = done_cnt; w0 = wa_q.size();
      @(posedge clk_i); #1;
      count_i = '0; base_addr_i = 10'h123; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(negedge clk_i);
      check("c0_done_early", 32'(done_o), 32'd0);
      check("c0_busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      check("c0_done", 32'(done_o), 32'd1);
      check("c0_m_valid", 32'(m_valid_o), 32'd0);
      #1;
      check("c0_no_writes", 32'(wa_q.size() - w0), 32'd0);
      check("c0_one_done", 32'(done_cnt - d0), 32'd1);

      // reset mid-burst with a word pending on the output
      m_ready_i = 1'b0;
      start_burst(10'h050, 11'd4);
      send("rm_w0", 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd7);
      @(negedge clk_i);
      check("rm_pending", 32'(m_valid_o), 32'd1);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("rm_m_valid", 32'(m_valid_o), 32'd0);
      check("rm_busy", 32'(busy_o), 32'd0);
      check("rm_s_ready", 32'(s_ready_o), 32'd0);
      rst_i = 1'b0;
      m_ready_i = 1'b1;

      // legal random bundles must round-trip through the decoder's immgen
      wa_q.delete(); wd_q.delete(); exp_imm.delete();
      start_burst(10'h100, 11'd24);
      for (int n = 0; n < 24; n++) begin
         k  = $urandom_range(0, 8);
         f3 = 3'($urandom_range(0, 7));
         r  = $urandom;
         case (k)
            0: begin op = 7'h13; imm = (f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5) ?
                                        {20'b0, r[11:0]} : {{20{r[11]}}, r[11:0]}; end
            1: begin op = 7'h03; imm = (f3 == 3'd4 || f3 == 3'd5) ?
                                        {20'b0, r[11:0]} : {{20{r[11]}}, r[11:0]}; end
            2: begin op = 7'h67; imm = {{20{r[11]}}, r[11:0]}; end
            3: begin op = 7'h73; imm = {{20{r[11]}}, r[11:0]}; end
            4: begin op = 7'h23; imm = {{20{r[11]}}, r[11:0]}; end
            5: begin op = 7'h63; imm = (f3 == 3'd6 || f3 == 3'd7) ?
                                        {19'b0, r[11:0], 1'b0} : {{19{r[11]}}, r[11:0], 1'b0}; end
            6: begin op = 7'h6F; imm = {{11{r[19]}}, r[19:0], 1'b0}; end
            7: begin op = 7'h37; imm = {r[19:0], 12'b0}; end
            default: begin op = 7'h17; imm = {r[31:12], 12'b0}; end
         endcase
         exp_imm.push_back(imm);
         send("rnd", op, f3, 5'(r[4:0]), 5'(r[9:5]), 5'(r[14:10]), imm);
      end
      wait_done("rnd");
      check("rnd_nwrites", 32'(wa_q.size()), 32'd24);
      for (int n = 0; n < 24; n++)
         check($sformatf("rnd_imm%0d", n), immgen(wr_data(n)), exp_imm[n]);
      check("rnd_err", 32'(err_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
